// File: rtl/aes128_word_io.sv
// 32-bit word wrapper around a combinational AES-128 core: packs key/data words in, unpacks ciphertext.
// Optional macro AES128_IO_KEYCHK_EN adds a sticky key_err output for blocks started without a full key.
module aes128_word_io #(
  parameter int unsigned CORE_WAIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_key,
  input  logic [31:0]  in_word,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic [127:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_word,
  output logic         busy
`ifdef AES128_IO_KEYCHK_EN
  ,
  output logic         key_err
`endif
);

  typedef enum logic [1:0] {StLoad, StWait, StDrain} state_e;

  localparam logic [3:0] WaitLast = 4'(CORE_WAIT);

  state_e       state;
  logic [1:0]   key_cnt;
  logic [1:0]   data_cnt;
  logic         key_ok;
  logic [3:0]   wait_cnt;
  logic [1:0]   out_idx;
  logic [127:0] out_buf;

  // The output register shifts left on each handshake, so the head word is always [127:96].
  assign out_word = out_buf[127:96];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StLoad;
      core_data <= '0;
      core_key  <= '0;
      out_buf   <= '0;
      key_cnt   <= '0;
      data_cnt  <= '0;
      key_ok    <= 1'b0;
      wait_cnt  <= '0;
      out_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef AES128_IO_KEYCHK_EN
      key_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StLoad: begin
          if (in_valid && in_ready) begin
            if (in_key) begin
              core_key <= {core_key[95:0], in_word};
              key_cnt  <= key_cnt + 2'd1;
              if (key_cnt == 2'd3) key_ok <= 1'b1;
            end else begin
              core_data <= {core_data[95:0], in_word};
              data_cnt  <= data_cnt + 2'd1;
              if (data_cnt == 2'd3) begin
                state    <= StWait;
                wait_cnt <= '0;
                in_ready <= 1'b0;
                busy     <= 1'b1;
`ifdef AES128_IO_KEYCHK_EN
                if (!key_ok || key_cnt != 2'd0) key_err <= 1'b1;
`endif
              end
            end
          end
        end
        StWait: begin
          if (wait_cnt == WaitLast) begin
            out_buf   <= core_result;
            out_idx   <= '0;
            state     <= StDrain;
            out_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        StDrain: begin
          if (out_ready) begin
            out_buf <= {out_buf[95:0], 32'h0};
            out_idx <= out_idx + 2'd1;
            if (out_idx == 2'd3) begin
              state     <= StLoad;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_word_io.sv
// Directed bench for aes128_word_io; the core is a known-answer stand-in for the FIPS-197 vector.
module tb_aes128_word_io;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_key;
  logic [31:0]  in_word;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic [127:0] core_result;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic         busy;
`ifdef AES128_IO_KEYCHK_EN
  logic         key_err;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] KeyRef = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtRef  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtRef  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [31:0] key_w [4];
  logic [31:0] dat_w [4];
  logic [31:0] exp_w [4];

  // Returns the FIPS-197 ciphertext only for the exact key/plaintext pair, garbage otherwise.
  always_comb begin
    core_result = ~core_data ^ core_key;
    if (core_key == KeyRef && core_data == PtRef) core_result = CtRef;
  end

  aes128_word_io #(.CORE_WAIT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .in_word    (in_word),
    .core_data  (core_data),
    .core_key   (core_key),
    .core_result(core_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .busy       (busy)
`ifdef AES128_IO_KEYCHK_EN
    ,
    .key_err    (key_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one word from a negedge; it is accepted at the following posedge.
  task automatic send(input logic k, input logic [31:0] w);
    @(negedge clk);
    chk("in_ready_load", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_key   = k;
    in_word  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called right after the 4th data word has been accepted (end of cycle T).
  task automatic run_block(input string tag, input int stall);
    out_ready = (stall == 0);
    @(negedge clk);
    chk({tag, "_t1_in_ready"}, 128'(in_ready), 128'd0);
    chk({tag, "_t1_busy"}, 128'(busy), 128'd1);
    chk({tag, "_t1_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_t1_core_data"}, core_data, PtRef);
    @(negedge clk);
    chk({tag, "_t2_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_t2_core_key"}, core_key, KeyRef);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_out_valid"}, 128'(out_valid), 128'd1);
      chk({tag, "_out_word"}, 128'(out_word), 128'(exp_w[i]));
      chk({tag, "_drain_in_ready"}, 128'(in_ready), 128'd0);
      if (i == 0 && stall > 0) begin
        for (int s = 1; s < stall; s++) begin
          @(negedge clk);
          chk({tag, "_stall_valid"}, 128'(out_valid), 128'd1);
          chk({tag, "_stall_word"}, 128'(out_word), 128'(exp_w[0]));
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk({tag, "_end_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_end_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_end_busy"}, 128'(busy), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_out_word"}, 128'(out_word), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_core_key"}, core_key, 128'd0);
    chk({tag, "_core_data"}, core_data, 128'd0);
  endtask

  initial begin
    key_w = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    dat_w = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    exp_w = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    rst = 1'b1;
    in_valid = 1'b0;
    in_key = 1'b0;
    in_word = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");
`ifdef AES128_IO_KEYCHK_EN
    chk("reset_key_err", 128'(key_err), 128'd0);
`endif

    // V1: full key then data
    for (int i = 0; i < 4; i++) send(1'b1, key_w[i]);
    for (int i = 0; i < 4; i++) send(1'b0, dat_w[i]);
    run_block("v1", 0);

    // V2: key persists, data only
    for (int i = 0; i < 4; i++) send(1'b0, dat_w[i]);
    run_block("v2", 0);

    // V3: sink stalls for 5 cycles at the first output word
    for (int i = 0; i < 4; i++) send(1'b0, dat_w[i]);
    run_block("v3", 5);

    // V4: reset during WAIT discards the block
    for (int i = 0; i < 4; i++) send(1'b0, dat_w[i]);
    @(negedge clk);
    chk("v4_in_wait_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("v4_rst");
    repeat (3) begin
      @(negedge clk);
      chk("v4_no_output", 128'(out_valid), 128'd0);
    end
    for (int i = 0; i < 4; i++) send(1'b1, key_w[i]);
    for (int i = 0; i < 4; i++) send(1'b0, dat_w[i]);
    run_block("v4_reload", 0);

    // V5: interleaved key and data words from a clean reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, key_w[i]);
      send(1'b0, dat_w[i]);
    end
    run_block("v5", 0);
`ifdef AES128_IO_KEYCHK_EN
    chk("v5_key_err", 128'(key_err), 128'd0);

    // V6: data without a key sets a sticky error; the block still completes
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b0, dat_w[i]);
    @(negedge clk);
    chk("v6_key_err_t1", 128'(key_err), 128'd1);
    repeat (8) @(negedge clk);
    chk("v6_block_done", 128'(in_ready), 128'd1);
    chk("v6_key_err_sticky", 128'(key_err), 128'd1);
    do_reset();
    chk("v6_key_err_cleared", 128'(key_err), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
